level_timer: RTL and testbench
==============================

Name: level_timer

Overview:
- Per-level countdown timer directly downstream of the game-level FSM.
- Consumes `timer_enable` and the `lvl1`/`lvl2`/`lvl3` one-hot level flags.
- Counts seconds down in 3-digit BCD for the HEX display.
- Emits a one-cycle `time_up` pulse, which the top level ORs into the FSM's `dead` input to force a return to the start screen.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per one-second tick; legal range 2..2^26.
- START_BCD, 12'h300: reload value in packed BCD {hundreds, tens, ones}; every nibble must be ≤ 9.
- WARN_BCD, 12'h030: warning threshold in packed BCD. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- timer_enable  in  1  high while any level is being played.
- lvl1  in  1  level-1 active flag.
- lvl2  in  1  level-2 active flag.
- lvl3  in  1  level-3 active flag.
- secs_bcd  out  12  remaining seconds as packed BCD.
- running  out  1  high while in the RUN state.
- time_up  out  1  one-cycle pulse when the count reaches 0.
- warn  out  1  low-time warning; tied to 0 when the optional feature is absent.

Behaviour:
- All outputs are registered.
- Reset (synchronous, wins over everything):
  - state = IDLE, secs_bcd = START_BCD, prescaler = 0.
  - running = 0, time_up = 0, warn = 0, lvl_prev = 3'b000.
- Level-edge detect: lvl_prev <= {lvl3, lvl2, lvl1} every cycle. lvl_rise = {lvl3, lvl2, lvl1} & ~lvl_prev.
- States: IDLE, RUN, EXPIRED.
- IDLE:
  - secs_bcd is held at START_BCD and prescaler = 0.
  - timer_enable = 1 → RUN next cycle; running goes high in the same edge.
- RUN, normal counting:
  - The prescaler counts 0..TICK_DIV-1.
  - tick = (prescaler == TICK_DIV-1); on tick the prescaler wraps to 0.
  - On tick, secs_bcd is decremented by 1 in BCD. Each digit 0 → 9 borrows from the next digit up; the hundreds digit never underflows because 000 is terminal.
- RUN, expiry:
  - A tick while secs_bcd == 12'h001 loads secs_bcd = 0, pulses time_up = 1 for exactly one cycle, and moves to EXPIRED.
- RUN, level change:
  - Any bit of lvl_rise set reloads secs_bcd = START_BCD and prescaler = 0, staying in RUN.
  - A level reload wins over a coincident tick, including the expiry tick: no time_up in that case.
- RUN, disable:
  - timer_enable = 0 → IDLE with a reload.
  - Disable wins over both reload and tick.
- EXPIRED:
  - secs_bcd is held at 0 and running = 0.
  - timer_enable = 0 → IDLE with a reload.
  - Level edges are ignored while in EXPIRED.
- Latency:
  - From timer_enable rising, the first decrement lands TICK_DIV cycles after RUN is entered.
  - time_up asserts on the same edge that secs_bcd becomes 000.
- START_BCD = 12'h000 is illegal.
- The prescaler is sized as $clog2(TICK_DIV) bits, with no overflow beyond TICK_DIV-1.

Optional Feature:
- Macro: LEVEL_TIMER_WARN_EN.
- Defined: warn is a registered signal, high when state == RUN and secs_bcd ≤ WARN_BCD. A plain unsigned compare is valid because the values are legal BCD. warn clears on the cycle after any reload or exit from RUN.
- Undefined: warn is constant 0 and no compare logic is generated.

Decomposition:
- Package level_timer_pkg holds:
  - the state encoding constants (IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2);
  - BCD_DIGITS = 3;
  - BCD_W = 12.
- One sub-module, bcd_digit_down: a single-digit BCD decrementer.
  - Inputs: digit[3:0], borrow_in.
  - Outputs: digit_next[3:0], borrow_out.
  - It is instantiated three times in a borrow chain.

Test Plan (TICK_DIV = 4, START_BCD = 12'h012, WARN_BCD = 12'h005):
1. Reset held 2 cycles, then released with timer_enable = 0 → secs_bcd = 012, running = 0, time_up = 0, held for 20 cycles.
2. timer_enable = 1, lvl1 = 1 → running = 1 next edge. secs_bcd steps 012 → 011 → 010 → 009 → …, one step every 4 cycles; the 010 → 009 step checks the borrow. Reaching 000 pulses time_up for exactly 1 cycle and enters EXPIRED, with running = 0 and secs_bcd held at 000.
3. In RUN at secs_bcd = 003, drop lvl1 and raise lvl2 → secs_bcd = 012 next edge, prescaler restarts, no time_up. Repeat the lvl2 rise coincident with the 001 → 000 tick → reload to 012 and no time_up.
4. In RUN, drop timer_enable mid-count, including on a tick cycle → IDLE, secs_bcd = 012, running = 0. Re-raising it restarts the count from 012.
5. Assert reset mid-RUN at secs_bcd = 007 → next edge gives IDLE, secs_bcd = 012, all outputs 0, even if timer_enable stays high during reset.
6. With LEVEL_TIMER_WARN_EN defined: warn = 0 at 006 and rises on the edge secs_bcd becomes 005. It clears on a level reload. Without the macro, warn = 0 throughout scenario 2.

Source files
------------

// File: rtl/level_timer_pkg.sv
// Shared definitions for the level countdown timer.
//   - state_t    : timer FSM encoding (IDLE / RUN / EXPIRED)
//   - BCD_DIGITS : number of BCD digits shown on the HEX display
//   - BCD_W      : packed width of the BCD count
//   - bcd_legal  : true when every nibble of a packed BCD value is <= 9
package level_timer_pkg;

    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    function automatic logic bcd_legal(input logic [BCD_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/level_timer_bcd_digit_down.sv
// Single BCD digit decrementer, one link of a borrow chain.
// Ports:
//   digit      in  4  current digit (0..9)
//   borrow_in  in  1  decrement request from the digit below (or the tick)
//   digit_next out 4  digit after the optional decrement (0 wraps to 9)
//   borrow_out out 1  this digit wrapped, so the next digit up must decrement
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_next = 4'd9;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/level_timer.sv
// Per-level countdown timer fed by the game-level FSM. Counts seconds down in
// 3-digit BCD and pulses time_up for one cycle when the count reaches 000.
// A rising edge on any level flag while running reloads the count.
// Optional feature macro: LEVEL_TIMER_WARN_EN (registered low-time warning).
// Ports:
//   clk           in   1   system clock, rising edge
//   reset         in   1   synchronous, active-high
//   timer_enable  in   1   high while a level is being played
//   lvl1/2/3      in   1   one-hot level-active flags
//   secs_bcd      out  12  remaining seconds, packed BCD {hundreds,tens,ones}
//   running       out  1   high in RUN
//   time_up       out  1   one-cycle pulse as the count lands on 000
//   warn          out  1   count at or below WARN_BCD while running (0 if feature absent)
module level_timer
    import level_timer_pkg::*;
#(
    parameter int               TICK_DIV  = 50_000_000,
    parameter logic [BCD_W-1:0] START_BCD = 12'h300,
    parameter logic [BCD_W-1:0] WARN_BCD  = 12'h030
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_enable,
    input  logic             lvl1,
    input  logic             lvl2,
    input  logic             lvl3,
    output logic [BCD_W-1:0] secs_bcd,
    output logic             running,
    output logic             time_up,
    output logic             warn
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Elaboration-time parameter sanity checks.
    if (TICK_DIV < 2 || TICK_DIV > (1 << 26)) begin : g_bad_tick_div
        $error("level_timer: TICK_DIV out of range");
    end
    if (START_BCD == '0 || !bcd_legal(START_BCD)) begin : g_bad_start
        $error("level_timer: START_BCD must be non-zero legal BCD");
    end
    if (!bcd_legal(WARN_BCD)) begin : g_bad_warn
        $error("level_timer: WARN_BCD must be legal BCD");
    end

    state_t           state_q, state_n;
    logic [BCD_W-1:0] secs_q, secs_n;
    logic [PW-1:0]    presc_q, presc_n;
    logic             running_q, running_n;
    logic             time_up_q, time_up_n;
    logic             warn_q, warn_n;
    logic [2:0]       lvl_prev_q;

    logic [2:0] lvl_now, lvl_rise;
    logic       tick;

    assign lvl_now  = {lvl3, lvl2, lvl1};
    assign lvl_rise = lvl_now & ~lvl_prev_q;
    assign tick     = (presc_q == TICK_LAST);

    // Borrow chain: always decrement by one; the result is used only on tick.
    logic [BCD_DIGITS-1:0][3:0] digits, dec_digits;
    logic [BCD_DIGITS:0]        borrow;
    logic [BCD_W-1:0]           secs_dec;

    assign digits    = secs_q;
    assign borrow[0] = 1'b1;

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
        bcd_digit_down u_digit (
            .digit     (digits[d]),
            .borrow_in (borrow[d]),
            .digit_next(dec_digits[d]),
            .borrow_out(borrow[d+1])
        );
    end

    // A borrow out of the hundreds digit means the count was already 000;
    // that is terminal, so saturate rather than wrap to 999.
    assign secs_dec = borrow[BCD_DIGITS] ? '0 : dec_digits;

    always_comb begin
        state_n   = state_q;
        secs_n    = secs_q;
        presc_n   = presc_q;
        running_n = running_q;
        time_up_n = 1'b0;
        unique case (state_q)
            IDLE: begin
                secs_n  = START_BCD;
                presc_n = '0;
                if (timer_enable) begin
                    state_n   = RUN;
                    running_n = 1'b1;
                end
            end
            RUN: begin
                // Priority: disable > level reload > tick.
                if (!timer_enable) begin
                    state_n   = IDLE;
                    secs_n    = START_BCD;
                    presc_n   = '0;
                    running_n = 1'b0;
                end else if (|lvl_rise) begin
                    secs_n  = START_BCD;
                    presc_n = '0;
                end else if (tick) begin
                    presc_n = '0;
                    if (secs_q == BCD_W'(1)) begin
                        secs_n    = '0;
                        time_up_n = 1'b1;
                        state_n   = EXPIRED;
                        running_n = 1'b0;
                    end else begin
                        secs_n = secs_dec;
                    end
                end else begin
                    presc_n = presc_q + 1'b1;
                end
            end
            EXPIRED: begin
                secs_n    = '0;
                presc_n   = '0;
                running_n = 1'b0;
                if (!timer_enable) begin
                    state_n = IDLE;
                    secs_n  = START_BCD;
                end
            end
            default: begin
                state_n   = IDLE;
                secs_n    = START_BCD;
                presc_n   = '0;
                running_n = 1'b0;
            end
        endcase

        // Warn is judged on the values being loaded, so it rises on the edge
        // the count reaches WARN_BCD and drops with any reload or RUN exit.
`ifdef LEVEL_TIMER_WARN_EN
        warn_n = (state_n == RUN) && (secs_n <= WARN_BCD);
`else
        warn_n = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            secs_q     <= START_BCD;
            presc_q    <= '0;
            running_q  <= 1'b0;
            time_up_q  <= 1'b0;
            warn_q     <= 1'b0;
            lvl_prev_q <= 3'b000;
        end else begin
            secs_q     <= secs_n;
            presc_q    <= presc_n;
            running_q  <= running_n;
            time_up_q  <= time_up_n;
            warn_q     <= warn_n;
            lvl_prev_q <= lvl_now;
        end
    end

    assign secs_bcd = secs_q;
    assign running  = running_q;
    assign time_up  = time_up_q;
    assign warn     = warn_q;

endmodule

// File: tb/tb_level_timer.sv
module tb_level_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        timer_enable = 1'b0;
    logic        lvl1 = 1'b0, lvl2 = 1'b0, lvl3 = 1'b0;
    logic [11:0] secs_bcd;
    logic        running, time_up, warn;

    int passed = 0;
    int total  = 0;

`ifdef LEVEL_TIMER_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    // Count sequence after entering RUN from 012, one entry per tick.
    logic [11:0] seq [12] = '{12'h011, 12'h010, 12'h009, 12'h008, 12'h007, 12'h006,
                              12'h005, 12'h004, 12'h003, 12'h002, 12'h001, 12'h000};

    level_timer #(.TICK_DIV(4), .START_BCD(12'h012), .WARN_BCD(12'h005)) dut (
        .clk         (clk),
        .reset       (reset),
        .timer_enable(timer_enable),
        .lvl1        (lvl1),
        .lvl2        (lvl2),
        .lvl3        (lvl3),
        .secs_bcd    (secs_bcd),
        .running     (running),
        .time_up     (time_up),
        .warn        (warn)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; timer_enable = 1'b0;
        step(2);
        total++; if (secs_bcd !== 12'h012) $display("FAIL reset_secs got=%h exp=012", secs_bcd); else passed++;
        total++; if ({running, time_up, warn} !== 3'b000) $display("FAIL reset_outs got=%b exp=000", {running, time_up, warn}); else passed++;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            total++;
            if (secs_bcd !== 12'h012 || running !== 1'b0 || time_up !== 1'b0)
                $display("FAIL idle_hold[%0d] got secs=%h run=%b tu=%b exp 012/0/0", i, secs_bcd, running, time_up);
            else passed++;
        end
    endtask

    task automatic test_count;
        logic [11:0] prev;
        timer_enable = 1'b1; lvl1 = 1'b1;
        step(1);
        total++; if (running !== 1'b1 || secs_bcd !== 12'h012) $display("FAIL enter_run got run=%b secs=%h exp 1/012", running, secs_bcd); else passed++;
        prev = 12'h012;
        for (int k = 0; k < 12; k++) begin
            step(3);
            total++; if (secs_bcd !== prev) $display("FAIL pre_tick[%0d] got=%h exp=%h", k, secs_bcd, prev); else passed++;
            step(1);
            total++; if (secs_bcd !== seq[k]) $display("FAIL tick[%0d] got=%h exp=%h", k, secs_bcd, seq[k]); else passed++;
            total++; if (time_up !== (k == 11)) $display("FAIL time_up[%0d] got=%b exp=%b", k, time_up, (k == 11)); else passed++;
            total++; if (running !== (k != 11)) $display("FAIL running[%0d] got=%b exp=%b", k, running, (k != 11)); else passed++;
            total++;
            if (warn !== (WARN_ON && seq[k] <= 12'h005 && k != 11))
                $display("FAIL warn[%0d] got=%b exp=%b", k, warn, (WARN_ON && seq[k] <= 12'h005 && k != 11));
            else passed++;
            prev = seq[k];
        end
        step(1);
        total++; if (time_up !== 1'b0 || secs_bcd !== 12'h000 || running !== 1'b0)
            $display("FAIL expired_hold got tu=%b secs=%h run=%b exp 0/000/0", time_up, secs_bcd, running); else passed++;
        // Level edges must be ignored in EXPIRED.
        lvl3 = 1'b1;
        step(2);
        total++; if (secs_bcd !== 12'h000 || running !== 1'b0 || time_up !== 1'b0)
            $display("FAIL expired_lvl got secs=%h run=%b tu=%b exp 000/0/0", secs_bcd, running, time_up); else passed++;
        lvl3 = 1'b0;
        step(1);
    endtask

    task automatic test_level_reload;
        timer_enable = 1'b0;
        step(1);
        total++; if (secs_bcd !== 12'h012 || running !== 1'b0) $display("FAIL exp_to_idle got secs=%h run=%b exp 012/0", secs_bcd, running); else passed++;
        timer_enable = 1'b1;
        step(1);
        total++; if (running !== 1'b1) $display("FAIL rerun got=%b exp=1", running); else passed++;
        step(36);
        total++; if (secs_bcd !== 12'h003) $display("FAIL reach_003 got=%h exp=003", secs_bcd); else passed++;
        total++; if (warn !== WARN_ON) $display("FAIL warn_003 got=%b exp=%b", warn, WARN_ON); else passed++;
        lvl1 = 1'b0; lvl2 = 1'b1;
        step(1);
        total++; if (secs_bcd !== 12'h012 || time_up !== 1'b0) $display("FAIL lvl_reload got secs=%h tu=%b exp 012/0", secs_bcd, time_up); else passed++;
        total++; if (warn !== 1'b0) $display("FAIL warn_reload got=%b exp=0", warn); else passed++;
        step(3);
        total++; if (secs_bcd !== 12'h012) $display("FAIL presc_restart got=%h exp=012", secs_bcd); else passed++;
        step(1);
        total++; if (secs_bcd !== 12'h011) $display("FAIL after_reload got=%h exp=011", secs_bcd); else passed++;
        step(40);
        total++; if (secs_bcd !== 12'h001) $display("FAIL reach_001 got=%h exp=001", secs_bcd); else passed++;
        step(2);
        lvl2 = 1'b0;
        step(1);
        lvl2 = 1'b1;
        step(1);   // expiry tick coincides with lvl2 rise
        total++; if (secs_bcd !== 12'h012 || time_up !== 1'b0 || running !== 1'b1)
            $display("FAIL reload_vs_expiry got secs=%h tu=%b run=%b exp 012/0/1", secs_bcd, time_up, running); else passed++;
        step(4);
        total++; if (secs_bcd !== 12'h011) $display("FAIL after_reload2 got=%h exp=011", secs_bcd); else passed++;
    endtask

    task automatic test_disable;
        step(1);
        timer_enable = 1'b0;
        step(1);
        total++; if (secs_bcd !== 12'h012 || running !== 1'b0 || time_up !== 1'b0)
            $display("FAIL disable_mid got secs=%h run=%b tu=%b exp 012/0/0", secs_bcd, running, time_up); else passed++;
        timer_enable = 1'b1;
        step(1);
        total++; if (running !== 1'b1) $display("FAIL reenable got=%b exp=1", running); else passed++;
        step(3);
        timer_enable = 1'b0;
        step(1);   // tick edge, disable wins
        total++; if (secs_bcd !== 12'h012 || running !== 1'b0) $display("FAIL disable_tick got secs=%h run=%b exp 012/0", secs_bcd, running); else passed++;
        step(1);
        total++; if (running !== 1'b0 || secs_bcd !== 12'h012) $display("FAIL idle_stay got run=%b secs=%h exp 0/012", running, secs_bcd); else passed++;
        timer_enable = 1'b1;
        step(1);
        total++; if (running !== 1'b1 || secs_bcd !== 12'h012) $display("FAIL restart got run=%b secs=%h exp 1/012", running, secs_bcd); else passed++;
        step(4);
        total++; if (secs_bcd !== 12'h011) $display("FAIL restart_tick got=%h exp=011", secs_bcd); else passed++;
    endtask

    task automatic test_reset_mid_run;
        step(16);
        total++; if (secs_bcd !== 12'h007) $display("FAIL reach_007 got=%h exp=007", secs_bcd); else passed++;
        reset = 1'b1;
        step(1);
        total++; if (secs_bcd !== 12'h012) $display("FAIL midreset_secs got=%h exp=012", secs_bcd); else passed++;
        total++; if ({running, time_up, warn} !== 3'b000) $display("FAIL midreset_outs got=%b exp=000", {running, time_up, warn}); else passed++;
        step(1);
        total++; if (running !== 1'b0) $display("FAIL reset_hold got=%b exp=0", running); else passed++;
        reset = 1'b0;
        step(1);
        total++; if (running !== 1'b1 || secs_bcd !== 12'h012) $display("FAIL post_reset_run got run=%b secs=%h exp 1/012", running, secs_bcd); else passed++;
        step(4);
        total++; if (secs_bcd !== 12'h011) $display("FAIL post_reset_tick got=%h exp=011", secs_bcd); else passed++;
    endtask

    initial begin
        test_reset();
        test_count();
        test_level_reload();
        test_disable();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
